switch_allocator: RTL and testbench
===================================

// Module: switch_allocator
// PURPOSE
// - Registered separable input-first round-robin switch allocator for one router.
// - Consumes per-input output-port requests from route computation.
// - Produces the one-hot-per-row allocation vector that the crossbar select
//   logic converts into per-input output selects and per-output input selects.
// - Guarantees a legal matching every cycle: at most one output per input and
//   at most one input per output. Round-robin pointers prevent starvation.
// PARAMETERS
// - NUM_PORT      6  number of router ports (4-LOCAL,3-N,2-S,1-E,0-W, plus port 5)
// - LOG_NUM_PORT  3  width of a port index; must satisfy 2**LOG_NUM_PORT >= NUM_PORT
// PORTS
// - clk          in   1                    single clock; all state on rising edge
// - rst_n        in   1                    asynchronous, active-low reset
// - stall        in   1                    1 = freeze allocVector and all pointers
// - reqVector    in   NUM_PORT*NUM_PORT    row i = [i*NUM_PORT+:NUM_PORT], requests of
//                                          input i; bit k set = input i wants output k
//                                          (multi-hot allowed)
// - allocVector  out  NUM_PORT*NUM_PORT    same row layout; row i one-hot (grant to
//                                          output k) or all-zero (no grant); registered
// - grantVector  out  NUM_PORT             bit i = OR of allocVector row i; registered
// BEHAVIOUR
// - Reset (rst_n=0, async): allocVector=0, grantVector=0, every inPtr[i]=0,
//   every outPtr[k]=0. Takes effect immediately, including mid-allocation.
// - Latency: reqVector sampled at edge t -> allocVector/grantVector valid after edge t.
//   Outputs change only on clock edges; no combinational path req->alloc.
// - Stage 1 (input arbitration): each input i with nonzero row selects exactly one
//   requested output. Search starts at inPtr[i], ascending, wrapping NUM_PORT-1 -> 0.
// - Stage 2 (output arbitration): each output k selects one input among those whose
//   stage-1 choice is k. Search starts at outPtr[k], ascending, with wrap.
// - Final grant (i,k) sets allocVector bit i*NUM_PORT+k for the next cycle. All other
//   bits are 0. Inputs losing stage 2 get an all-zero row that cycle; no second
//   iteration is performed.
// - Pointer update, only for final grants and only when stall=0:
//   - inPtr[i] <= (k+1) mod NUM_PORT
//   - outPtr[k] <= (i+1) mod NUM_PORT
//   - Pointers of ungranted inputs and outputs hold.
// - Wrap arithmetic: NUM_PORT need not be a power of 2; explicit compare gives
//   ptr==NUM_PORT-1 -> 0. Pointer values >= NUM_PORT are never produced.
// - Request bits at index >= NUM_PORT do not exist. An all-zero row never wins.
// - stall=1: allocVector, grantVector and all pointers hold their values.
//   reqVector is ignored that cycle.
// - Simultaneous stall=1 and rst_n=0: reset wins.
// - No requests: allocVector=0 next cycle, pointers unchanged.
// TESTING (NUM_PORT=6; rows listed as input:bits[5:0])
// 1. Reset, then idle reqVector=0
//    -> allocVector=0 and grantVector=0 both during and after reset.
// 2. Single request, in2:010000 for one cycle
//    -> next cycle row2=010000, grantVector=000100, then 0.
//    Then in2:010000 again -> granted again; outPtr[4]=3 does not block a lone requester.
// 3. Held contention, in0:000010 and in3:000010 held for 4 cycles
//    -> grants alternate in0, in3, in0, in3. Never both in one cycle.
// 4. Multi-hot input, in5:000101 held
//    -> first grant is output 0 (inPtr=0), next is output 2 (inPtr=1), then output 0.
// 5. Permutation, inputs 0..5 request outputs 5,4,3,2,1,0 respectively
//    -> all six granted in the same cycle; grantVector=111111.
// 6. Stall and async reset
//    - Drive scenario 3. Assert stall for 2 cycles while changing reqVector
//      -> allocVector frozen and alternation resumes in order after stall=0.
//    - Drop rst_n between edges -> allocVector=0 immediately and the first grant
//      afterwards goes to in0.

Source files
------------

// File: rtl/switch_allocator.sv
// -----------------------------------------------------------------------------
// switch_allocator
// Registered separable input-first round-robin switch allocator for a router.
//
// Stage 1: every input with a non-empty request row picks one requested output,
//          searching upward from its own round-robin pointer (with wrap).
// Stage 2: every output picks one input among those that chose it in stage 1,
//          searching upward from its own round-robin pointer (with wrap).
// The surviving (input, output) pairs form a legal matching that is registered
// into allocVector. Only the pointers of matched inputs and outputs advance,
// each to one position past the partner it was just matched with.
//
// Ports
//   clk          in   1                  rising-edge clock
//   rst_n        in   1                  asynchronous active-low reset
//   stall        in   1                  1 = hold allocVector, grantVector, pointers
//   reqVector    in   NUM_PORT*NUM_PORT  row i = requests of input i (multi-hot)
//   allocVector  out  NUM_PORT*NUM_PORT  row i one-hot grant or zero (registered)
//   grantVector  out  NUM_PORT           bit i = OR of allocVector row i (registered)
// -----------------------------------------------------------------------------
module switch_allocator #(
    parameter int NUM_PORT     = 6,
    parameter int LOG_NUM_PORT = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic [NUM_PORT*NUM_PORT-1:0] reqVector,
    output logic [NUM_PORT*NUM_PORT-1:0] allocVector,
    output logic [NUM_PORT-1:0]          grantVector
);

    localparam int unsigned NP = NUM_PORT;

    // Round-robin pointers: inPtr per input (over outputs), outPtr per output
    // (over inputs).
    logic [LOG_NUM_PORT-1:0] inPtr      [NP];
    logic [LOG_NUM_PORT-1:0] outPtr     [NP];
    logic [LOG_NUM_PORT-1:0] inPtrNext  [NP];
    logic [LOG_NUM_PORT-1:0] outPtrNext [NP];

    // inChoice[i][k]: stage-1 pick of input i is output k (one-hot or zero).
    // outSel[k][i]  : stage-2 pick of output k is input i (one-hot or zero).
    logic [NP-1:0] inChoice [NP];
    logic [NP-1:0] outSel   [NP];

    logic [NUM_PORT*NUM_PORT-1:0] allocNext;
    logic [NUM_PORT-1:0]          grantNext;

    // (base + off) mod NP for base, off < NP; explicit compare because NP is
    // not necessarily a power of two.
    function automatic int unsigned wrapAdd(input int unsigned base,
                                            input int unsigned off);
        int unsigned s;
        s = base + off;
        if (s >= NP) begin
            s = s - NP;
        end
        return s;
    endfunction

    // (v + 1) mod NP as a pointer value; never yields a value >= NP.
    function automatic logic [LOG_NUM_PORT-1:0] wrapInc(input int unsigned v);
        if (v >= NP - 1) begin
            return '0;
        end
        return LOG_NUM_PORT'(v + 1);
    endfunction

    // Stage 1: input arbitration.
    always_comb begin
        for (int unsigned i = 0; i < NP; i++) begin
            inChoice[i] = '0;
        end
        for (int unsigned i = 0; i < NP; i++) begin
            logic        found;
            int unsigned idx;
            found = 1'b0;
            idx   = 0;
            for (int unsigned j = 0; j < NP; j++) begin
                idx = wrapAdd(32'(inPtr[i]), j);
                if (!found && reqVector[i*NP + idx]) begin
                    inChoice[i][idx] = 1'b1;
                    found            = 1'b1;
                end
            end
        end
    end

    // Stage 2: output arbitration over the stage-1 picks.
    always_comb begin
        for (int unsigned k = 0; k < NP; k++) begin
            outSel[k] = '0;
        end
        for (int unsigned k = 0; k < NP; k++) begin
            logic        found;
            int unsigned idx;
            found = 1'b0;
            idx   = 0;
            for (int unsigned j = 0; j < NP; j++) begin
                idx = wrapAdd(32'(outPtr[k]), j);
                if (!found && inChoice[idx][k]) begin
                    outSel[k][idx] = 1'b1;
                    found          = 1'b1;
                end
            end
        end
    end

    // Final matching and pointer advance for matched pairs only.
    always_comb begin
        allocNext = '0;
        grantNext = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            inPtrNext[i]  = inPtr[i];
            outPtrNext[i] = outPtr[i];
        end
        for (int unsigned i = 0; i < NP; i++) begin
            for (int unsigned k = 0; k < NP; k++) begin
                if (outSel[k][i]) begin
                    allocNext[i*NP + k] = 1'b1;
                    grantNext[i]        = 1'b1;
                    inPtrNext[i]        = wrapInc(k);
                    outPtrNext[k]       = wrapInc(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            allocVector <= '0;
            grantVector <= '0;
            for (int unsigned i = 0; i < NP; i++) begin
                inPtr[i]  <= '0;
                outPtr[i] <= '0;
            end
        end else if (!stall) begin
            allocVector <= allocNext;
            grantVector <= grantNext;
            for (int unsigned i = 0; i < NP; i++) begin
                inPtr[i]  <= inPtrNext[i];
                outPtr[i] <= outPtrNext[i];
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// -----------------------------------------------------------------------------
// tb_switch_allocator
// Directed scoreboard bench for switch_allocator (NUM_PORT = 6). The driver
// applies one request pattern per cycle on the falling edge and queues the
// hand-computed allocation expected after the next rising edge; an independent
// monitor pops and compares one entry shortly after every rising edge.
// -----------------------------------------------------------------------------
module tb_switch_allocator;

    localparam int NP = 6;
    localparam int W  = NP * NP;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic [W-1:0]  reqVector;
    logic [W-1:0]  allocVector;
    logic [NP-1:0] grantVector;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        string        name;
        logic [W-1:0] alloc;
    } expEntry;

    expEntry expQ[$];

    switch_allocator #(
        .NUM_PORT     (NP),
        .LOG_NUM_PORT (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .reqVector   (reqVector),
        .allocVector (allocVector),
        .grantVector (grantVector)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rowBits(input int unsigned i, input logic [NP-1:0] bits);
        logic [W-1:0] r;
        r = '0;
        r[i*NP +: NP] = bits;
        return r;
    endfunction

    function automatic logic [NP-1:0] grantOf(input logic [W-1:0] a);
        logic [NP-1:0] g;
        for (int i = 0; i < NP; i++) begin
            g[i] = |a[i*NP +: NP];
        end
        return g;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkNow(input string name, input logic [W-1:0] exp);
        check({name, "_alloc"}, allocVector, exp);
        check({name, "_grant"}, {{(W-NP){1'b0}}, grantVector}, {{(W-NP){1'b0}}, grantOf(exp)});
    endtask

    task automatic drive(input logic [W-1:0] req, input logic st,
                         input logic [W-1:0] exp, input string name);
        expEntry e;
        @(negedge clk);
        reqVector = req;
        stall     = st;
        e.name    = name;
        e.alloc   = exp;
        expQ.push_back(e);
    endtask

    // Monitor: outputs are registered, so every cycle presents one result.
    initial begin
        expEntry e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkNow(e.name, e.alloc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] g0, g3, req3, reqPerm, expPerm;
        g0   = rowBits(0, 6'b000010);
        g3   = rowBits(3, 6'b000010);
        req3 = g0 | g3;
        reqPerm = '0;
        for (int i = 0; i < NP; i++) begin
            logic [NP-1:0] b;
            b = '0;
            b[NP-1-i] = 1'b1;
            reqPerm = reqPerm | rowBits(i, b);
        end
        expPerm = reqPerm;

        // 1. reset (asserted by an actual falling edge), idle
        rst_n     = 1'b1;
        stall     = 1'b0;
        reqVector = '0;
        #1 rst_n = 1'b0;
        #1 checkNow("s1_async_reset", '0);
        drive('0, 1'b0, '0, "s1_in_reset0");
        drive(req3, 1'b0, '0, "s1_in_reset_req");
        @(posedge clk);
        #2 rst_n = 1'b1;
        drive('0, 1'b0, '0, "s1_idle0");
        drive('0, 1'b0, '0, "s1_idle1");

        // 2. lone requester, twice (outPtr[4] moves to 3 but must not block)
        drive(rowBits(2, 6'b010000), 1'b0, rowBits(2, 6'b010000), "s2_first");
        drive('0, 1'b0, '0, "s2_gap");
        drive(rowBits(2, 6'b010000), 1'b0, rowBits(2, 6'b010000), "s2_again");
        drive('0, 1'b0, '0, "s2_idle");

        // 3. held contention on output 1
        drive(req3, 1'b0, g0, "s3_c0");
        drive(req3, 1'b0, g3, "s3_c1");
        drive(req3, 1'b0, g0, "s3_c2");
        drive(req3, 1'b0, g3, "s3_c3");
        drive('0, 1'b0, '0, "s3_idle");

        // 4. multi-hot input 5 walks its pointer: 0, 2, 0
        drive(rowBits(5, 6'b000101), 1'b0, rowBits(5, 6'b000001), "s4_c0");
        drive(rowBits(5, 6'b000101), 1'b0, rowBits(5, 6'b000100), "s4_c1");
        drive(rowBits(5, 6'b000101), 1'b0, rowBits(5, 6'b000001), "s4_c2");
        drive('0, 1'b0, '0, "s4_idle");

        // 5. full permutation
        drive(reqPerm, 1'b0, expPerm, "s5_perm");
        drive('0, 1'b0, '0, "s5_idle");

        // 6. contention, stall with changed requests, resume, async reset
        drive(req3, 1'b0, g0, "s6_c0");
        drive(req3, 1'b0, g3, "s6_c1");
        drive(rowBits(2, 6'b000001) | rowBits(4, 6'b100000), 1'b1, g3, "s6_stall0");
        drive('1, 1'b1, g3, "s6_stall1");
        drive(req3, 1'b0, g0, "s6_resume0");
        drive(req3, 1'b0, g3, "s6_resume1");
        drive(req3, 1'b0, g0, "s6_resume2");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 checkNow("s6_async_reset", '0);
        drive(req3, 1'b1, '0, "s6_reset_and_stall");
        @(posedge clk);
        #2 rst_n = 1'b1;
        drive(req3, 1'b0, g0, "s6_after_reset0");
        drive(req3, 1'b0, g3, "s6_after_reset1");
        drive('0, 1'b0, '0, "s6_idle");

        @(posedge clk);
        #3;
        assertCount++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
